// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
// The byte-lane merge helper is also used by the data-memory bridge.
package timer_counter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 4;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_e;

  // Lane i takes new data where its byte enable is set, else keeps the old byte.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [3:0]        be
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Programmable countdown timer on the M-stage data bus: CTRL/PRESET/COUNT
// registers, combinational read mux and a one-shot / auto-reload FSM.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tmr_state_e        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              pending_q, pending_d;
  logic              irq_q;

  logic              hit_c;
  logic              ctrl_wr_c;
  logic              preset_wr_c;
  logic [CTRL_W-1:0] ctrl_new_c;
  logic              en_eff_c;
  logic [1:0]        mode_eff_c;
  logic              fsm_clr_en_c;
  logic              unused_addr_c;

  assign unused_addr_c = ^addr[1:0];

  // Address decode; the fourth word of the window is unmapped.
  assign hit_c       = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'b11);
  assign ctrl_wr_c   = hit_c && (|byteen) && (addr[3:2] == OFF_CTRL[3:2]);
  assign preset_wr_c = hit_c && (|byteen) && (addr[3:2] == OFF_PRESET[3:2]);
  assign ctrl_new_c  = CTRL_W'(merge_bytes({28'd0, ctrl_q}, wdata, byteen));

  // A same-cycle CTRL write decides EN for this edge's transition.
  assign en_eff_c   = ctrl_wr_c ? ctrl_new_c[CTRL_EN] : ctrl_q[CTRL_EN];
  assign mode_eff_c = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) ?
                      MODE_RELOAD : MODE_ONESHOT;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= pending_d & ctrl_d[CTRL_IM];
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pending_d    = pending_q;
    fsm_clr_en_c = 1'b0;
    ctrl_d       = ctrl_wr_c ? ctrl_new_c : ctrl_q;
    preset_d     = preset_wr_c ? merge_bytes(preset_q, wdata, byteen) : preset_q;

    if (ctrl_wr_c) pending_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_eff_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!en_eff_c) begin
          state_d = ST_IDLE;
        end else begin
          count_d = preset_q;
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!en_eff_c) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d   = '0;
          pending_d = 1'b1;
          state_d   = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_eff_c == MODE_RELOAD) begin
          pending_d = 1'b0;
          state_d   = en_eff_c ? ST_LOAD : ST_IDLE;
        end else begin
          fsm_clr_en_c = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The CPU write wins over the FSM clearing EN.
    if (fsm_clr_en_c && !ctrl_wr_c) ctrl_d[CTRL_EN] = 1'b0;
  end

  always_comb begin
    rdata = '0;
    if (hit_c) begin
      case (addr[3:2])
        OFF_CTRL[3:2]:   rdata = {28'd0, ctrl_q};
        OFF_PRESET[3:2]: rdata = preset_q;
        OFF_COUNT[3:2]:  rdata = count_q;
        default:         rdata = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register-access vector table followed by
// hand-written counting, reload, reset and preset sequences.
module tb_timer_counter;

  localparam logic [31:0] A_CTRL = 32'h0000_7F00;
  localparam logic [31:0] A_PRE  = 32'h0000_7F04;
  localparam logic [31:0] A_CNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RES  = 32'h0000_7F0C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  timer_counter #(.BASE(32'h0000_7F00)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr   = a;
    wdata  = d;
    byteen = be;
    tick();
    byteen = 4'h0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr   = a;
    byteen = 4'h0;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    chk(name, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    vecs[0]  = '{A_CTRL, 4'h0, 32'h0,          32'h0,          1'b0};
    vecs[1]  = '{A_PRE,  4'h0, 32'h0,          32'h0,          1'b0};
    vecs[2]  = '{A_CNT,  4'h0, 32'h0,          32'h0,          1'b0};
    vecs[3]  = '{A_RES,  4'h0, 32'h0,          32'h0,          1'b0};
    vecs[4]  = '{A_PRE,  4'hF, 32'h1122_3344,  32'h0,          1'b0};
    vecs[5]  = '{A_PRE,  4'h2, 32'h0000_AB00,  32'h1122_3344,  1'b0};
    vecs[6]  = '{A_PRE,  4'h0, 32'h0,          32'h1122_AB44,  1'b0};
    vecs[7]  = '{A_CNT,  4'hF, 32'hFFFF_FFFF,  32'h0,          1'b0};
    vecs[8]  = '{A_CNT,  4'h0, 32'h0,          32'h0,          1'b0};
    vecs[9]  = '{A_RES,  4'hF, 32'hDEAD_BEEF,  32'h0,          1'b0};
    vecs[10] = '{A_RES,  4'h0, 32'h0,          32'h0,          1'b0};
    vecs[11] = '{A_PRE,  4'h0, 32'h0,          32'h1122_AB44,  1'b0};
    vecs[12] = '{A_CTRL, 4'hF, 32'hFFFF_FFF6,  32'h0,          1'b0};
    vecs[13] = '{A_CTRL, 4'h0, 32'h0,          32'h0000_0006,  1'b0};
    vecs[14] = '{32'h1000_7F04, 4'hF, 32'h55,  32'h0,          1'b0};
    vecs[15] = '{A_PRE,  4'h0, 32'h0,          32'h1122_AB44,  1'b0};
    vecs[16] = '{32'h0000_7F07, 4'h0, 32'h0,   32'h1122_AB44,  1'b0};
    vecs[17] = '{A_CTRL, 4'h1, 32'h0,          32'h0000_0006,  1'b0};
    vecs[18] = '{A_CTRL, 4'h0, 32'h0,          32'h0,          1'b0};
    vecs[19] = '{32'h0000_7E00, 4'h0, 32'h0,   32'h0,          1'b0};

    reset  = 1'b0;
    addr   = 32'h0;
    byteen = 4'h0;
    wdata  = 32'h0;
    tick();
    tick();
    reset = 1'b1;

    // Register access table; rdata is sampled before the edge (old contents).
    for (int i = 0; i < NVEC; i++) begin
      addr   = vecs[i].addr;
      byteen = vecs[i].be;
      wdata  = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      irq_chk($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
      tick();
      byteen = 4'h0;
    end

    // Reset asserted mid-count.
    wr(A_PRE, 32'd5, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    tick();
    rd_chk("rst_pre_count", A_CNT, 32'd5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rd_chk("rst_count", A_CNT, 32'd0);
    rd_chk("rst_ctrl", A_CTRL, 32'd0);
    rd_chk("rst_preset", A_PRE, 32'd0);
    irq_chk("rst_irq", 1'b0);
    repeat (3) tick();
    rd_chk("rst_idle_count", A_CNT, 32'd0);

    // One-shot, PRESET=3.
    wr(A_PRE, 32'd3, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    addr = A_CNT;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("os_count_e%0d", k), rdata, 32'(4 - k));
      irq_chk($sformatf("os_irq_e%0d", k), k == 4);
    end
    tick();
    tick();
    irq_chk("os_irq_hold", 1'b1);
    rd_chk("os_ctrl_en_cleared", A_CTRL, 32'h8);
    wr(A_CTRL, 32'h8, 4'hF);
    irq_chk("os_irq_cleared", 1'b0);

    // Auto-reload, PRESET=2: one-cycle pulse every 4 cycles.
    wr(A_PRE, 32'd2, 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    for (int k = 1; k <= 14; k++) begin
      tick();
      irq_chk($sformatf("ar_irq_e%0d", k), (k >= 3) && (((k - 3) % 4) == 0));
    end
    wr(A_CTRL, 32'h0, 4'hF);
    irq_chk("ar_stop_irq", 1'b0);
    rd_chk("ar_stop_count", A_CNT, 32'd1);
    tick();
    tick();
    rd_chk("ar_idle_count", A_CNT, 32'd1);

    // PRESET=0 behaves like 1; IM=0 keeps irq low with pending set.
    wr(A_PRE, 32'd0, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    tick();
    irq_chk("p0_irq_e1", 1'b0);
    tick();
    irq_chk("p0_irq_e2", 1'b1);
    wr(A_CTRL, 32'h1, 4'hF);
    irq_chk("p0_irq_cleared", 1'b0);
    tick();
    tick();
    tick();
    irq_chk("im0_irq", 1'b0);
    chk("im0_pending", {31'd0, dut.pending_q}, 32'd1);
    tick();
    rd_chk("im0_ctrl_en_cleared", A_CTRL, 32'h0);
    chk("im0_pending_hold", {31'd0, dut.pending_q}, 32'd1);
    wr(A_CTRL, 32'h0, 4'hF);
    chk("im0_pending_cleared", {31'd0, dut.pending_q}, 32'd0);

    // PRESET write during CNT, stop, then restart from the new preset.
    wr(A_PRE, 32'd5, 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    tick();
    tick();
    rd_chk("pw_count_before", A_CNT, 32'd4);
    wr(A_PRE, 32'd7, 4'hF);
    rd_chk("pw_count_after_prewrite", A_CNT, 32'd3);
    wr(A_CTRL, 32'h8, 4'hF);
    rd_chk("pw_count_frozen", A_CNT, 32'd3);
    tick();
    tick();
    rd_chk("pw_count_still_frozen", A_CNT, 32'd3);
    rd_chk("pw_preset", A_PRE, 32'd7);
    wr(A_CTRL, 32'h9, 4'hF);
    tick();
    rd_chk("pw_restart_count", A_CNT, 32'd7);
    tick();
    rd_chk("pw_restart_dec", A_CNT, 32'd6);
    wr(A_CTRL, 32'h0, 4'hF);

    // EN cleared while in LOAD: COUNT must not be reloaded.
    wr(A_CTRL, 32'h9, 4'hF);
    wr(A_CTRL, 32'h8, 4'hF);
    tick();
    rd_chk("load_abort_count", A_CNT, 32'd6);
    tick();
    rd_chk("load_abort_idle", A_CNT, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
